uart_rx_param: RTL and testbench
================================

// Module: uart_rx_param
// PURPOSE
//   Parametrised UART receiver, successor to the fixed 8N1 Bluetooth receiver.
//   Sits between the HC-05 module RxD pin and the command decoder.
//   Adds configurable baud, frame format, input synchroniser and false-start rejection.
//   Adds a valid/ready holding register with frame, parity and overrun error flags.
// PARAMETERS
//   CLK_HZ     100_000_000  system clock frequency in Hz
//   BAUD       9_600        line rate; BIT_DIV = CLK_HZ/BAUD (integer), HALF = BIT_DIV>>1
//   DATA_BITS  8            data bits per frame, legal range 5..9, sent LSB first
//   STOP_BITS  1            1 or 2; every stop bit is checked
//   PARITY_ODD 0            0 = even, 1 = odd; used only when UART_RX_PARITY_EN is defined
// PORTS
//   clk         in   1          system clock, all logic on posedge
//   rst_n       in   1          asynchronous reset, active low
//   rxd         in   1          serial line, idle high, asynchronous to clk
//   rx_ready    in   1          consumer accepts rx_data when rx_valid && rx_ready
//   rx_data     out  DATA_BITS  last accepted frame, held stable while rx_valid=1
//   rx_valid    out  1          holding register full
//   frame_err   out  1          1-cycle pulse: a stop bit was sampled low
//   parity_err  out  1          1-cycle pulse: parity mismatch (tied 0 without macro)
//   overrun     out  1          sticky: frame completed while rx_valid=1; clears on handshake
//   busy        out  1          FSM not in IDLE
// BEHAVIOUR
//   - Reset (rst_n=0, any time, incl. mid-frame): FSM=IDLE, counters=0, rx_data=0,
//     rx_valid=0, frame_err=0, parity_err=0, overrun=0, busy=0; synchroniser flops set to 1.
//   - rxd passes through a 2-flop synchroniser (rxd_s); every reference below is to rxd_s.
//   - FSM states: IDLE, START, DATA, PARITY, STOP.
//     IDLE: cnt=0; rxd_s=0 -> START.
//     START: count to HALF-1; sample rxd_s: 0 -> DATA, cnt=0; 1 -> IDLE (false start, no flags).
//     DATA: sample every BIT_DIV cycles; shift in LSB first; after DATA_BITS samples -> PARITY
//       if the macro is defined, else -> STOP.
//     PARITY: one sample at BIT_DIV; compare with the XOR of the data bits (^PARITY_ODD) -> STOP.
//     STOP: STOP_BITS samples spaced BIT_DIV apart. After the last one -> IDLE at once.
//       Do not wait for the end of the stop bit, so back-to-back frames resync.
//   - Frame completion, registered on the cycle after the last stop sample:
//     any stop bit 0 -> frame_err=1 for 1 cycle; data discarded; rx_valid unchanged.
//     parity mismatch (stop good) -> parity_err=1 for 1 cycle; data discarded.
//     good frame and (rx_valid=0 or rx_ready=1 this cycle) -> rx_data<=frame, rx_valid<=1.
//     good frame and rx_valid=1 and rx_ready=0 -> frame dropped, overrun<=1; rx_data kept.
//   - Handshake: rx_valid&&rx_ready with no new frame that cycle -> rx_valid<=0, overrun<=0.
//     A simultaneous good frame refills the register (rx_valid stays 1, overrun<=0).
//   - Latency: from the rxd falling edge, the last stop sample lands at
//     2 + HALF + BIT_DIV*(DATA_BITS + P + STOP_BITS) cycles (P = 1 if parity enabled).
//     rx_valid rises on the next cycle.
//   - Counter width $clog2(BIT_DIV+1); bit counter width $clog2(DATA_BITS+1); no wrap inside a frame.
//   - busy=1 from the cycle after START entry until the return to IDLE.
// CONFIGURATION
//   UART_RX_PARITY_EN defined: PARITY state present; frame has 1 parity bit;
//     parity_err active as above.
//   Not defined: no PARITY state, frame = start + DATA_BITS + STOP_BITS;
//     parity_err tied to 0; PARITY_ODD ignored.
// TESTING  (CLK_HZ=1_000_000, BAUD=100_000 -> BIT_DIV=10, HALF=5, 8N1 unless noted)
//   1. Send 0x55 then 0xA3 back-to-back, rx_ready=1
//      -> rx_valid on cycle 98 after the first edge; rx_data=0x55, then 0xA3; no error flags.
//   2. rxd low for 3 cycles then high -> no rx_valid; busy back to 0 within 8 cycles; no flags.
//   3. Send 0x3C with stop bit forced 0 -> frame_err pulses 1 cycle; rx_valid stays 0;
//      the next good frame 0x12 is received correctly.
//   4. rx_ready=0, send 0x11 then 0x22 -> rx_data=0x11, overrun=1;
//      raise rx_ready 1 cycle -> rx_valid=0, overrun=0.
//   5. STOP_BITS=2: send 0x7E with second stop bit 0 -> frame_err pulse, no rx_valid.
//      With UART_RX_PARITY_EN, PARITY_ODD=0: 0x01 with parity bit 0 -> parity_err pulse, no rx_valid.
//   6. Assert rst_n=0 mid-DATA of 0xFF
//      -> all outputs 0 in the same cycle; after release an idle line gives no rx_valid;
//         the next frame 0x81 is received correctly.

Source files
------------

// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver with input synchroniser, false-start rejection and valid/ready holding register.
// Define UART_RX_PARITY_EN to add a parity bit after the data bits.
module uart_rx_param #(
   parameter int CLK_HZ     = 100_000_000,
   parameter int BAUD       = 9_600,
   parameter int DATA_BITS  = 8,
   parameter int STOP_BITS  = 1,
   parameter bit PARITY_ODD = 1'b0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 rxd,
   input  logic                 rx_ready,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 frame_err,
   output logic                 parity_err,
   output logic                 overrun,
   output logic                 busy
);
   localparam int BIT_DIV = CLK_HZ / BAUD;
   localparam int HALF = BIT_DIV >> 1;
   localparam int CW = $clog2(BIT_DIV + 1);
   localparam int BW = $clog2(DATA_BITS + 1);
   localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
   localparam logic [CW-1:0] BIT_M1 = CW'(BIT_DIV - 1);
   localparam logic [BW-1:0] DATA_M1 = BW'(DATA_BITS - 1);
   localparam logic [BW-1:0] STOP_M1 = BW'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      IDLE, START, DATA,
`ifdef UART_RX_PARITY_EN
      PARITY,
`endif
      STOP
   } state_t;

   state_t state;
   logic [1:0] sync;
   logic rxd_s;
   logic [CW-1:0] cnt;
   logic [BW-1:0] bcnt;
   logic [DATA_BITS-1:0] sh;
   logic stop_good, fin, good;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync <= 2'b11;
      else sync <= {sync[0], rxd};
   end
   assign rxd_s = sync[1];
   assign busy = state != IDLE;

`ifdef UART_RX_PARITY_EN
   logic par_good;
   assign good = fin & stop_good & par_good;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) parity_err <= 1'b0;
      else parity_err <= fin & stop_good & ~par_good;
   end
`else
   assign good = fin & stop_good;
   assign parity_err = PARITY_ODD & 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt <= '0;
         bcnt <= '0;
         sh <= '0;
         stop_good <= 1'b1;
         fin <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_good <= 1'b1;
`endif
      end else begin
         fin <= 1'b0;
         case (state)
            IDLE: begin
               // the detection cycle already counts toward the half-bit wait
               cnt <= rxd_s ? '0 : CW'(1);
               bcnt <= '0;
               stop_good <= 1'b1;
`ifdef UART_RX_PARITY_EN
               par_good <= 1'b1;
`endif
               if (!rxd_s) state <= START;
            end
            START: begin
               cnt <= cnt + CW'(1);
               if (cnt >= HALF_M1) begin
                  cnt <= '0;
                  state <= rxd_s ? IDLE : DATA;
               end
            end
            DATA: begin
               cnt <= cnt + CW'(1);
               if (cnt == BIT_M1) begin
                  cnt <= '0;
                  sh <= {rxd_s, sh[DATA_BITS-1:1]};
                  bcnt <= bcnt + BW'(1);
                  if (bcnt == DATA_M1) begin
                     bcnt <= '0;
`ifdef UART_RX_PARITY_EN
                     state <= PARITY;
`else
                     state <= STOP;
`endif
                  end
               end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
               cnt <= cnt + CW'(1);
               if (cnt == BIT_M1) begin
                  cnt <= '0;
                  par_good <= rxd_s == (^sh ^ PARITY_ODD);
                  state <= STOP;
               end
            end
`endif
            STOP: begin
               cnt <= cnt + CW'(1);
               if (cnt == BIT_M1) begin
                  cnt <= '0;
                  bcnt <= bcnt + BW'(1);
                  stop_good <= stop_good & rxd_s;
                  // leave mid-stop-bit so a back-to-back start edge is caught
                  if (bcnt == STOP_M1) begin
                     bcnt <= '0;
                     fin <= 1'b1;
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_data <= '0;
         rx_valid <= 1'b0;
         frame_err <= 1'b0;
         overrun <= 1'b0;
      end else begin
         frame_err <= fin & ~stop_good;
         if (good && (!rx_valid || rx_ready)) begin
            rx_data <= sh;
            rx_valid <= 1'b1;
            overrun <= 1'b0;
         end else if (good) begin
            overrun <= 1'b1;
         end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
            overrun <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: scoreboard bench for uart_rx_param at BIT_DIV=10 (8N1 and 8N2 instances).
module tb_uart_rx_param;
   localparam int BD = 10;
`ifdef UART_RX_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif
   logic clk = 1'b0, rst_n = 1'b0;
   logic rxd_a = 1'b1, rxd_b = 1'b1, rdy_a = 1'b1;
   logic [7:0] data_a, data_b, exp_a, exp_b;
   logic val_a, val_b, fe_a, fe_b, pe_a, pe_b, ov_a, ov_b, busy_a, busy_b;
   logic fe_prev_a = 1'b0, fe_prev_b = 1'b0, pe_prev_a = 1'b0;
   int errors = 0, checks = 0;
   int fe_cnt_a = 0, fe_cnt_b = 0, pe_cnt_a = 0, pe_cnt_b = 0;
   int lat, fe0, pe0;
   logic [7:0] q_a[$];
   logic [7:0] q_b[$];

   always #5 clk = ~clk;

   uart_rx_param #(.CLK_HZ(1_000_000), .BAUD(100_000)) u_a (
      .clk(clk), .rst_n(rst_n), .rxd(rxd_a), .rx_ready(rdy_a), .rx_data(data_a),
      .rx_valid(val_a), .frame_err(fe_a), .parity_err(pe_a), .overrun(ov_a), .busy(busy_a));

   uart_rx_param #(.CLK_HZ(1_000_000), .BAUD(100_000), .STOP_BITS(2)) u_b (
      .clk(clk), .rst_n(rst_n), .rxd(rxd_b), .rx_ready(1'b1), .rx_data(data_b),
      .rx_valid(val_b), .frame_err(fe_b), .parity_err(pe_b), .overrun(ov_b), .busy(busy_b));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit b, input logic v);
      if (b) rxd_b = v;
      else rxd_a = v;
   endtask

   // bad_stop selects a stop bit (1-based) driven low for its first half only
   task automatic send(input bit b, input logic [7:0] d, input int bad_stop, input int nstop, input bit flip_par);
      for (int k = 0; k < 9 + P + nstop; k++) begin
         logic v;
         int low;
         low = BD;
         if (k == 0) v = 1'b0;
         else if (k <= 8) v = d[k-1];
         else if (P == 1 && k == 9) v = ^d ^ flip_par;
         else begin
            v = 1'b1;
            if (k - 8 - P == bad_stop) begin
               v = 1'b0;
               low = BD / 2;
            end
         end
         drive(b, v);
         tick(low);
         if (low != BD) begin
            drive(b, 1'b1);
            tick(BD - low);
         end
      end
      drive(b, 1'b1);
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (val_a && rdy_a) begin
            checks++;
            if (q_a.size() == 0) begin
               errors++;
               $display("FAIL rx_a_unexpected: got %h expected no frame", data_a);
            end else begin
               exp_a = q_a.pop_front();
               if (data_a !== exp_a) begin
                  errors++;
                  $display("FAIL rx_a_data: got %h expected %h", data_a, exp_a);
               end
            end
         end
         if (val_b) begin
            checks++;
            if (q_b.size() == 0) begin
               errors++;
               $display("FAIL rx_b_unexpected: got %h expected no frame", data_b);
            end else begin
               exp_b = q_b.pop_front();
               if (data_b !== exp_b) begin
                  errors++;
                  $display("FAIL rx_b_data: got %h expected %h", data_b, exp_b);
               end
            end
         end
         if (fe_a) begin
            fe_cnt_a++;
            checks++;
            if (fe_prev_a) begin errors++; $display("FAIL fe_a_width: got 2+ cycles expected 1"); end
         end
         if (fe_b) begin
            fe_cnt_b++;
            checks++;
            if (fe_prev_b) begin errors++; $display("FAIL fe_b_width: got 2+ cycles expected 1"); end
         end
         if (pe_a) begin
            pe_cnt_a++;
            checks++;
            if (pe_prev_a) begin errors++; $display("FAIL pe_a_width: got 2+ cycles expected 1"); end
         end
         if (pe_b) pe_cnt_b++;
      end
      fe_prev_a = fe_a;
      fe_prev_b = fe_b;
      pe_prev_a = pe_a;
   end

   initial begin
      #500_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tick(3);
      chk("rst_valid", val_a, 0);
      chk("rst_data", data_a, 0);
      chk("rst_busy", busy_a, 0);
      chk("rst_ovr", ov_a, 0);
      rst_n = 1'b1;
      tick(5);
      // back-to-back frames with latency measurement
      lat = 0;
      fork
         begin
            q_a.push_back(8'h55);
            send(0, 8'h55, 0, 1, 0);
            q_a.push_back(8'hA3);
            send(0, 8'hA3, 0, 1, 0);
         end
         begin
            for (int i = 1; i <= 300 && lat == 0; i++) begin
               @(posedge clk);
               #1;
               if (val_a) lat = i;
            end
         end
      join
      tick(20);
      chk("t1_latency", lat, 98 + BD * P);
      chk("t1_frame_err", fe_cnt_a, 0);
      chk("t1_parity_err", pe_cnt_a, 0);
      chk("t1_drained", q_a.size(), 0);
      // false start
      drive(0, 1'b0);
      tick(3);
      drive(0, 1'b1);
      chk("t2_busy_mid", busy_a, 1);
      tick(5);
      chk("t2_busy_end", busy_a, 0);
      tick(100);
      chk("t2_no_flags", fe_cnt_a + pe_cnt_a, 0);
      // bad stop bit then good frame
      send(0, 8'h3C, 1, 1, 0);
      tick(30);
      chk("t3_frame_err", fe_cnt_a, 1);
      chk("t3_no_valid", val_a, 0);
      q_a.push_back(8'h12);
      send(0, 8'h12, 0, 1, 0);
      tick(20);
      chk("t3_drained", q_a.size(), 0);
      // overrun
      rdy_a = 1'b0;
      q_a.push_back(8'h11);
      send(0, 8'h11, 0, 1, 0);
      send(0, 8'h22, 0, 1, 0);
      tick(5);
      chk("t4_data", data_a, 8'h11);
      chk("t4_valid", val_a, 1);
      chk("t4_overrun", ov_a, 1);
      rdy_a = 1'b1;
      tick(1);
      rdy_a = 1'b0;
      chk("t4_valid_clr", val_a, 0);
      chk("t4_overrun_clr", ov_a, 0);
      chk("t4_drained", q_a.size(), 0);
      // two stop bits, second one low
      send(1, 8'h7E, 2, 2, 0);
      tick(30);
      chk("t5_frame_err", fe_cnt_b, 1);
      q_b.push_back(8'h5A);
      send(1, 8'h5A, 0, 2, 0);
      tick(20);
      chk("t5_drained", q_b.size(), 0);
`ifdef UART_RX_PARITY_EN
      fe0 = fe_cnt_a;
      pe0 = pe_cnt_a;
      send(0, 8'h01, 0, 1, 1);
      tick(30);
      chk("t5_parity_err", pe_cnt_a - pe0, 1);
      chk("t5_parity_no_fe", fe_cnt_a - fe0, 0);
      chk("t5_parity_no_valid", val_a, 0);
`endif
      // reset mid-frame with a full holding register
      send(0, 8'h44, 0, 1, 0);
      tick(5);
      chk("t6_pre_valid", val_a, 1);
      chk("t6_pre_data", data_a, 8'h44);
      fork
         send(0, 8'hFF, 0, 1, 0);
         begin
            tick(40);
            #3;
            rst_n = 1'b0;
            #1;
            chk("t6_busy", busy_a, 0);
            chk("t6_valid", val_a, 0);
            chk("t6_data", data_a, 0);
            chk("t6_flags", {fe_a, pe_a, ov_a}, 0);
            tick(3);
            rst_n = 1'b1;
         end
      join
      tick(30);
      rdy_a = 1'b1;
      tick(2);
      chk("t6_idle_no_valid", val_a, 0);
      q_a.push_back(8'h81);
      send(0, 8'h81, 0, 1, 0);
      tick(20);
      chk("end_q_a", q_a.size(), 0);
      chk("end_q_b", q_b.size(), 0);
      chk("end_b_parity", pe_cnt_b, 0);
      chk("end_b_idle", {busy_b, ov_b}, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
